// File: rtl/wvfm_loader.sv
// Waveform LUT reload sequencer: streams host bytes into the LUT write port
// during display blanking, tracking byte count and a 16-bit running checksum.
module wvfm_loader #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             frame_idle,
  input  logic             s_valid,
  input  logic [DBITS-1:0] s_data,
  output logic             s_ready,
  output logic             lut_we,
  output logic [ABITS-1:0] lut_addr,
  output logic [DBITS-1:0] lut_din,
  output logic             busy,
  output logic             done,
  output logic [ABITS:0]   count,
  output logic [15:0]      checksum
);

  // state     | meaning
  // IDLE      | no load pending; waits for start
  // WAIT_IDLE | load requested; waits for display blanking
  // LOAD      | accepting stream bytes while frame_idle is high
  // DONE      | last byte written; done pulses for this one cycle
  typedef enum logic [1:0] {IDLE, WAIT_IDLE, LOAD, DONE} state_t;

  localparam logic [ABITS-1:0] ADDR_LAST = '1;
  localparam logic [ABITS-1:0] ADDR_ONE  = ABITS'(1);
  localparam logic [ABITS:0]   CNT_ONE   = (ABITS + 1)'(1);

  state_t           state;
  logic [ABITS-1:0] addr_cnt;
  logic             hs;

  // The write port shares the read-A address path, so the gate is combinational
  // on frame_idle; abort suppresses a coincident handshake.
  assign s_ready  = (state == LOAD) && frame_idle && !abort;
  assign hs       = s_ready && s_valid;
  assign lut_we   = hs;
  assign lut_addr = addr_cnt;
  assign lut_din  = s_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_cnt <= '0;
      count    <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_cnt <= '0;
            count    <= '0;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (frame_idle) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (hs) begin
            addr_cnt <= addr_cnt + ADDR_ONE;
            count    <= count + CNT_ONE;
            checksum <= checksum + 16'(s_data);
            if (addr_cnt == ADDR_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wvfm_loader.sv
// Scoreboard bench for wvfm_loader: the driver queues each expected LUT write,
// and a negedge monitor pops and compares whenever lut_we is seen.
module tb_wvfm_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        frame_idle = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, lut_we, busy, done;
  logic [11:0] lut_addr;
  logic [7:0]  lut_din;
  logic [12:0] count;
  logic [15:0] checksum;

  wvfm_loader #(.ABITS(12), .DBITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_idle(frame_idle),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_din(lut_din), .busy(busy), .done(done),
    .count(count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_w;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_we = 0;
  int   n_done = 0;
  logic [15:0] model_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected write, present the byte, and return just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [11:0] a);
    int k;
    exp_q.push_back(wr_t'({a, d}));
    s_valid = 1'b1;
    s_data  = d;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: byte for addr %0d never accepted, s_ready=%0b", a, s_ready);
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (done) n_done++;
    if (lut_we) begin
      n_we++;
      chk("we_gate_idle_valid", {30'd0, frame_idle, s_valid}, 32'd3);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: lut_addr=%0d lut_din=%0h, want no write", lut_addr, lut_din);
      end else begin
        mon_w = exp_q.pop_front();
        chk("lut_addr", {20'd0, lut_addr}, {20'd0, mon_w.a});
        chk("lut_din", {24'd0, lut_din}, {24'd0, mon_w.d});
        chk("count_at_write", {19'd0, count}, {20'd0, mon_w.a});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_lut_we", {31'd0, lut_we}, 0);
    chk("rst_lut_addr", {20'd0, lut_addr}, 0);
    chk("rst_count", {19'd0, count}, 0);
    chk("rst_checksum", {16'd0, checksum}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Full load of i mod 256, with a 20-cycle blanking gap after 1000 bytes.
    frame_idle = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 1000; i++) send(i[7:0], i[11:0]);
    frame_idle = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hE8;
    repeat (20) begin
      @(negedge clk);
      chk("gap_s_ready", {31'd0, s_ready}, 0);
      chk("gap_lut_we", {31'd0, lut_we}, 0);
      chk("gap_count", {19'd0, count}, 1000);
    end
    tick();
    frame_idle = 1'b1;
    for (int i = 1000; i < 4096; i++) send(i[7:0], i[11:0]);
    s_valid = 1'b0;
    @(negedge clk);
    chk("full_done", {31'd0, done}, 1);
    chk("full_busy_in_done", {31'd0, busy}, 1);
    chk("full_count", {19'd0, count}, 4096);
    chk("full_checksum", {16'd0, checksum}, 32'h0000F800);
    @(negedge clk);
    chk("full_done_fall", {31'd0, done}, 0);
    chk("full_busy_fall", {31'd0, busy}, 0);
    tick();

    // Deferred start with blanking held off, then abort after 100 bytes of 0x01.
    frame_idle = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h01;
    repeat (50) begin
      @(negedge clk);
      chk("defer_busy", {31'd0, busy}, 1);
      chk("defer_s_ready", {31'd0, s_ready}, 0);
      chk("defer_lut_we", {31'd0, lut_we}, 0);
    end
    tick();
    frame_idle = 1'b1;
    for (int i = 0; i < 100; i++) send(8'h01, i[11:0]);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_s_ready", {31'd0, s_ready}, 0);
    chk("abort_lut_we", {31'd0, lut_we}, 0);
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_count", {19'd0, count}, 100);
    chk("abort_checksum", {16'd0, checksum}, 100);
    chk("abort_no_done", n_done, 1);
    tick();

    // Restart clears state; backpressured load with a stray start mid-way.
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("restart_count", {19'd0, count}, 0);
    chk("restart_checksum", {16'd0, checksum}, 0);
    chk("restart_lut_addr", {20'd0, lut_addr}, 0);
    chk("restart_busy", {31'd0, busy}, 1);
    tick();
    model_sum = 16'h0000;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      model_sum = model_sum + {8'h00, d};
      send(d, i[11:0]);
      s_valid = 1'b0;
      if (i == 4095) break;
      if (i == 500) start = 1'b1;
      tick();
      start = 1'b0;
    end
    @(negedge clk);
    chk("bp_done", {31'd0, done}, 1);
    chk("bp_count", {19'd0, count}, 4096);
    chk("bp_checksum", {16'd0, checksum}, {16'd0, model_sum});
    @(negedge clk);
    chk("bp_busy_fall", {31'd0, busy}, 0);
    tick();

    // Asynchronous reset in the middle of a load.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300; i++) send(i[7:0], i[11:0]);
    exp_q.push_back(wr_t'({12'd300, 8'h55}));
    s_valid = 1'b1;
    s_data = 8'h55;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_s_ready", {31'd0, s_ready}, 0);
    chk("arst_lut_we", {31'd0, lut_we}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_count", {19'd0, count}, 0);
    chk("arst_checksum", {16'd0, checksum}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle_busy", {31'd0, busy}, 0);
      chk("post_rst_idle_s_ready", {31'd0, s_ready}, 0);
    end
    s_valid = 1'b0;
    tick();

    chk("total_writes", n_we, 100 + 4096 + 4096 + 301);
    chk("total_done_pulses", n_done, 2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wvfm_loader.md
Name: wvfm_loader

Overview:
- Sequences a full waveform-table reload into the 4096x8 waveform LUT write port from a host byte stream (USB/SPI bridge side).
- Writes only while the display pipeline reports the LUT read port idle (frame blanking), because the LUT write port shares its address path with read port A.
- Counts written bytes, keeps a running 16-bit checksum, and reports busy/done to the control register block.

Parameters:
- ABITS, 12, LUT byte-address width; one load is 2^ABITS bytes.
- DBITS, 8, LUT write data width and stream byte width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a full-table load.
- abort  input  1  single-cycle request to cancel a load in progress.
- frame_idle  input  1  high while the display does not read the LUT (blanking).
- s_valid  input  1  stream byte valid.
- s_data  input  DBITS  stream byte.
- s_ready  output  1  loader accepts a byte this cycle.
- lut_we  output  1  LUT write enable.
- lut_addr  output  ABITS  LUT write address.
- lut_din  output  DBITS  LUT write data.
- busy  output  1  load pending or in progress.
- done  output  1  single-cycle pulse when the load completes.
- count  output  ABITS+1  bytes written in the current or last load.
- checksum  output  16  modulo-2^16 sum of the bytes written in the current or last load.

Behaviour:
- Reset values (async assert, and while rst is high): state IDLE, busy=0, done=0, s_ready=0, lut_we=0, lut_addr=0, count=0, checksum=0.
- FSM states are IDLE, WAIT_IDLE, LOAD, DONE.
  - IDLE: on start, clear the address counter, count and checksum, then go to WAIT_IDLE. abort is ignored in IDLE.
  - WAIT_IDLE: when frame_idle=1, go to LOAD. On abort, go to IDLE.
  - LOAD: s_ready = frame_idle and not abort (combinational). A handshake is s_valid and s_ready.
    - On a handshake, in the same cycle: lut_we=1, lut_addr = address counter, lut_din = s_data (combinational).
    - On the next edge: address +1, count +1, checksum += zero-extended s_data (wraps mod 2^16).
    - If the handshake is at address 2^ABITS-1, go to DONE; the address counter wraps to 0 and count becomes 2^ABITS.
    - On abort, go to IDLE. No write occurs in the abort cycle; count and checksum hold their values.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in WAIT_IDLE, LOAD and DONE.
- done rises in the cycle after the final handshake.
- lut_we is never asserted unless frame_idle=1 in the same cycle; lut_we=0 in every state other than LOAD.
- If frame_idle falls mid-load, s_ready drops in the same cycle. The loader stays in LOAD with address, count and checksum held, and resumes at the same address when frame_idle returns.
- start while busy=1 is ignored.
- If abort and a would-be handshake coincide, abort wins: no write occurs.
- s_data is don't-care whenever s_valid=0.
- After DONE or abort, lut_addr holds its last value but lut_we=0.
- Reset asserted mid-load takes effect immediately: the LUT contents are not restored, and the table is partially written.

Test Plan:
- Full load: start, frame_idle=1, stream 4096 bytes with value i mod 256 and s_valid always high.
  - Required: 4096 lut_we pulses with lut_addr 0..4095 and lut_din = addr[7:0].
  - Required: done pulses once, 1 cycle after the last accept; count=4096; checksum=0xF800; busy=0 one cycle after done.
- Blanking gate: drop frame_idle for 20 cycles after 1000 bytes.
  - Required: s_ready=0 and lut_we=0 for those 20 cycles; count holds at 1000.
  - Required: the next write, after frame_idle returns, goes to lut_addr=1000.
- Deferred start: start with frame_idle=0 for 50 cycles.
  - Required: busy=1, s_ready=0, no lut_we during those cycles; the first write occurs at lut_addr=0 once frame_idle=1.
- Abort: abort after 100 bytes of 0x01 while s_valid=1.
  - Required: no write in the abort cycle; busy=0 on the next cycle; done never pulses; count=100; checksum=100.
  - Required: a following start clears count and checksum to 0 and restarts at address 0.
- Ignored start and reset: pulse start mid-load; the address sequence is unaffected.
  - Assert rst asynchronously mid-load. Required: s_ready, lut_we, busy, done drop immediately; count=0, checksum=0, state IDLE.
- Backpressure: s_valid toggling 1,0,1,0 across a full load.
  - Required: writes occur only on valid cycles; addresses are contiguous with no skips or duplicates; the final checksum matches the bench model.
